// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner selection for one shared 4x1 multiplexer.
// Drives the mux selects {s1,s0}, a one-hot grant and a busy flag, all registered.
// Optional feature macro: MUX4_ARB_TIMEOUT_EN (forced release after MAX_HOLD
// grant cycles while another requester waits). Without it, hcnt is not built
// and MAX_HOLD has no effect.
//
// Handshake: a requester raises req[i] and must keep it high until gnt[i] is
// seen; it owns the mux for as long as it keeps req[i] high, and gives the mux
// back by dropping req[i]. Every change of owner passes through one cycle with
// gnt == 0, and {s1,s0} only move when a new grant is issued.
module mux4_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);
   logic [4:0] hcnt_q, hcnt_d;
   logic       others_req;
`else
   logic [4:0] unused_max_hold;
   assign unused_max_hold = 5'(MAX_HOLD);
`endif

   logic [1:0] win;
   logic       win_found;
   logic [1:0] idx;

   // Round-robin search: first asserted request in order ptr, ptr+1, ptr+2, ptr+3.
   always_comb begin
      win       = 2'd0;
      win_found = 1'b0;
      idx       = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!win_found && req[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end
   end

   // Next-state and output register values; a grant is issued only from IDLE or GAP.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
`ifdef MUX4_ARB_TIMEOUT_EN
      hcnt_d     = hcnt_q;
      others_req = |(req & ~gnt_q);
`endif
      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (win_found) begin
               state_d = ST_GRANT;
               ptr_d   = win + 2'd1;
               sel_d   = win;
               gnt_d   = 4'b0001 << win;
               busy_d  = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
               hcnt_d  = 5'd1;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!req[sel_q]) begin
               state_d = ST_GAP;
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
            end
`ifdef MUX4_ARB_TIMEOUT_EN
            else if (hcnt_q == HOLD_MAX && others_req) begin
               // Owner has used its slot while someone else waits: force a release.
               state_d = ST_GAP;
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
            end else if (hcnt_q < HOLD_MAX) begin
               hcnt_d = hcnt_q + 5'd1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         busy_q  <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
         hcnt_q  <= 5'd0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
`ifdef MUX4_ARB_TIMEOUT_EN
         hcnt_q  <= hcnt_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign s1   = sel_q[1];
   assign s0   = sel_q[0];
   assign busy = busy_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed and random request patterns; a reference model
// predicts {gnt, s1s0, busy} after every edge and a monitor compares.
module tb_mux4_arbiter;

`ifdef MUX4_ARB_TIMEOUT_EN
   localparam int MH = 4;
`else
   localparam int MH = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic       s1, s0, busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [6:0] exp_q[$];
   logic [3:0] gnt_log[$];
   bit         log_en = 1'b0;

   mux4_arbiter #(.MAX_HOLD(MH)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .s1   (s1),
      .s0   (s0),
      .busy (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Owner-level view: either someone owns the mux or nobody does. A free mux
   // is handed to the first requester from ptr onward; a released mux is
   // never handed over on the same edge, which yields the one-cycle gap.
   int m_owner = -1;
   int m_sel   = 0;
   int m_ptr   = 0;
   int m_hold  = 0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_owner = -1;
            m_sel   = 0;
            m_ptr   = 0;
            m_hold  = 0;
         end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_owner = -1;
            end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
               if (m_hold == MH && (req & ~(4'b0001 << m_owner)) != 4'b0000)
                  m_owner = -1;
               else if (m_hold < MH)
                  m_hold = m_hold + 1;
`endif
            end
         end else begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (!found && req[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_sel   = c;
                  m_ptr   = (c + 1) % 4;
                  m_hold  = 1;
               end
            end
         end
         if (m_owner >= 0)
            exp_q.push_back({4'b0001 << m_owner, 2'(m_sel), 1'b1});
         else
            exp_q.push_back({4'b0000, 2'(m_sel), 1'b0});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [6:0] exp;
      logic [3:0] prev_gnt;
      prev_gnt = 4'b0000;
      forever begin
         @(posedge clk);
         #1;
         cycle = cycle + 1;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard cycle %0d: no expected entry for output gnt=%b", cycle, gnt);
         end else begin
            exp = exp_q.pop_front();
            if ({gnt, s1, s0, busy} !== exp) begin
               errors = errors + 1;
               $display("FAIL outputs cycle %0d: got gnt=%b s1s0=%b%b busy=%b, expected gnt=%b s1s0=%b busy=%b",
                        cycle, gnt, s1, s0, busy, exp[6:3], exp[2:1], exp[0]);
            end
         end
         if (log_en && gnt != 4'b0000 && prev_gnt == 4'b0000)
            gnt_log.push_back(gnt);
         prev_gnt = gnt;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drive(input logic [3:0] r, input int n);
      req = r;
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] rr_exp[5];
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

      // Reset and single request
      req = 4'b0000;
      do_reset(2);
      drive(4'b0100, 3);
      drive(4'b0000, 3);

      // Round-robin: each owner drops req the cycle after it sees its grant
      do_reset(1);
      log_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req = 4'b1111 & ~gnt;
         @(negedge clk);
      end
      log_en = 1'b0;
      drive(4'b0000, 3);
      checks = checks + 1;
      if (gnt_log.size() < 5) begin
         errors = errors + 1;
         $display("FAIL rr_count: got %0d grants, expected at least 5", gnt_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks = checks + 1;
            if (gnt_log[i] !== rr_exp[i]) begin
               errors = errors + 1;
               $display("FAIL rr_order[%0d]: got gnt=%b expected %b", i, gnt_log[i], rr_exp[i]);
            end
         end
      end

      // Select stability: owner 1 holds while req[3] toggles
      drive(4'b0010, 1);
      for (int i = 0; i < 6; i++) drive({i[0], 3'b010}, 1);
      drive(4'b0000, 2);

      // Two steady requesters, then a lone requester
      drive(4'b0011, 24);
      drive(4'b0000, 2);
      drive(4'b0001, 24);
      drive(4'b0000, 2);

      // Reset mid-grant, then confirm pointer restart
      drive(4'b1000, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(4'b1111, 3);
      drive(4'b0000, 2);

      // Random traffic with occasional reset and held requests
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) != 0)
            req = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      rst = 1'b0;
      drive(4'b0000, 3);

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
